// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external registered-read RAM, with a 2-entry output skid buffer.
// Optional: define RAM_FIFO_OVF_ERR_EN to add a sticky ovf_err output for refused pushes.
module ram_fifo_ctrl #(
    parameter int unsigned RAM_WIDTH = 64,
    parameter int unsigned ADDR_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef RAM_FIFO_OVF_ERR_EN
    output logic                 ovf_err,
`endif
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [RAM_WIDTH-1:0] push_data,
    output logic                 pop_valid,
    input  logic                 pop_ready,
    output logic [RAM_WIDTH-1:0] pop_data,
    output logic [ADDR_SIZE:0]   count,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    output logic [ADDR_SIZE-1:0] ram_wr_address,
    output logic                 ram_write,
    output logic [ADDR_SIZE-1:0] ram_rd_address,
    output logic                 ram_read,
    input  logic [RAM_WIDTH-1:0] ram_data_out
);

    localparam int unsigned DEPTH = 2**ADDR_SIZE;
    localparam int unsigned CW    = ADDR_SIZE + 1;

    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_ptr;
    logic [CW-1:0]        r_mem_count;
    logic [CW-1:0]        r_count;
    logic [1:0]           r_ob_count;
    logic                 r_inflight;
    logic [RAM_WIDTH-1:0] r_ob0;
    logic [RAM_WIDTH-1:0] r_ob1;

    logic                 w_push_fire;
    logic                 w_pop_fire;
    logic [2:0]           w_ob_load;
    logic                 w_rd_fire;

    assign push_ready  = rst_n && (r_count < CW'(DEPTH));
    assign w_push_fire = push_valid && push_ready;
    assign pop_valid   = (r_ob_count != 2'd0);
    assign w_pop_fire  = pop_valid && pop_ready;

    // Buffer occupancy after this cycle's pop, counting the word already on its way from RAM.
    assign w_ob_load = {1'b0, r_ob_count} + {2'b00, r_inflight} - {2'b00, w_pop_fire};
    assign w_rd_fire = rst_n && (r_mem_count != CW'(0)) && (w_ob_load < 3'd2);

    assign ram_write      = w_push_fire;
    assign ram_wr_address = r_wr_ptr;
    assign ram_data_in    = push_data;
    assign ram_read       = w_rd_fire;
    assign ram_rd_address = r_rd_ptr;
    assign pop_data       = r_ob0;
    assign count          = r_count;

    // Pointers and occupancy counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_count     <= '0;
            r_inflight  <= 1'b0;
        end else begin
            if (w_push_fire) r_wr_ptr <= r_wr_ptr + ADDR_SIZE'(1);
            if (w_rd_fire)   r_rd_ptr <= r_rd_ptr + ADDR_SIZE'(1);
            case ({w_push_fire, w_rd_fire})
                2'b10:   r_mem_count <= r_mem_count + CW'(1);
                2'b01:   r_mem_count <= r_mem_count - CW'(1);
                default: r_mem_count <= r_mem_count;
            endcase
            case ({w_push_fire, w_pop_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_inflight <= w_rd_fire;
        end
    end

    // In-order skid buffer: r_ob0 is the head, RAM data lands at the tail.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ob_count <= 2'd0;
            r_ob0      <= '0;
            r_ob1      <= '0;
        end else if (r_inflight && w_pop_fire) begin
            if (r_ob_count == 2'd1) begin
                r_ob0 <= ram_data_out;
            end else begin
                r_ob0 <= r_ob1;
                r_ob1 <= ram_data_out;
            end
        end else if (r_inflight) begin
            if (r_ob_count == 2'd0) r_ob0 <= ram_data_out;
            else                    r_ob1 <= ram_data_out;
            r_ob_count <= r_ob_count + 2'd1;
        end else if (w_pop_fire) begin
            r_ob0      <= r_ob1;
            r_ob_count <= r_ob_count - 2'd1;
        end
    end

`ifdef RAM_FIFO_OVF_ERR_EN
    logic r_ovf_err;

    always_ff @(posedge clk) begin
        if (!rst_n)                         r_ovf_err <= 1'b0;
        else if (push_valid && !push_ready) r_ovf_err <= 1'b1;
    end

    assign ovf_err = r_ovf_err;
`endif

endmodule
